// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares a single combinational ALU
// between NREQ requesters. Each accepted operation's result is captured in a
// response register that is held until its owning requester takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | response register empty, any valid requester may be granted
// HOLD  | response register full for requester 'owner'; a new grant is
//       | allowed only in the cycle the owner accepts its response
module alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_ctrl,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_result,
    output logic                  resp_zero,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_control,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic            found;
    logic            own_ready;
    logic            can_issue;
    logic            grant;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Issue qualification; reset also holds req_ready low so nothing is taken
    // while the block is being cleared.
    always_comb begin
        own_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner == PW'(k)) own_ready = resp_ready[k];
        end
        can_issue = (state == IDLE) || ((state == HOLD) && own_ready);
        grant     = can_issue && found && reset;
    end

    // Handshake outputs and ALU operand mux; ALU inputs are zero when idle.
    always_comb begin
        req_ready   = '0;
        resp_valid  = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k]  = grant && (win == PW'(k));
            resp_valid[k] = (state == HOLD) && (owner == PW'(k));
            if (grant && (win == PW'(k))) begin
                alu_a       = req_a[k*WIDTH +: WIDTH];
                alu_b       = req_b[k*WIDTH +: WIDTH];
                alu_control = req_ctrl[k*3 +: 3];
            end
        end
    end

    // Next-state logic: a grant always (re)loads HOLD; owner acceptance
    // without a new grant empties the response register.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        if (grant) begin
            state_nxt  = HOLD;
            owner_nxt  = win;
            rr_ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end else if ((state == HOLD) && own_ready) begin
            state_nxt = IDLE;
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Response register captures the ALU output on every grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else if (grant) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [5:0]  req_ctrl;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [7:0]  resp_result;
    logic        resp_zero;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_control;
    logic [7:0]  alu_result;
    logic        alu_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NREQ(2), .WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU seen by the arbiter.
    logic [7:0] bb;
    logic [7:0] sum;
    always_comb begin
        bb  = alu_control[2] ? ~alu_b : alu_b;
        sum = alu_a + bb + {7'd0, alu_control[2]};
        case (alu_control[1:0])
            2'b00:   alu_result = alu_a & bb;
            2'b01:   alu_result = alu_a | bb;
            2'b10:   alu_result = sum;
            default: alu_result = {7'd0, sum[7]};
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    task automatic test_reset();
        reset      = 1'b0;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        resp_ready = 2'b00;
        #3;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (resp_result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", resp_result); end
        checks++; if (resp_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", resp_zero); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_drain_busy got %b want 0", name, busy); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL %s_drain_resp_valid got %b want 00", name, resp_valid); end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid     = 2'b01;
        req_a[7:0]    = 8'h05;
        req_b[7:0]    = 8'h03;
        req_ctrl[2:0] = 3'b010;
        resp_ready    = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b want 01", req_ready); end
        checks++; if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_control !== 3'b010)
            begin errors++; $display("FAIL single_alu_in got %h %h %b want 05 03 010", alu_a, alu_b, alu_control); end
        @(posedge clk); #1;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL single_resp_valid got %b want 01", resp_valid); end
        checks++; if (resp_result !== 8'h08) begin errors++; $display("FAIL single_result got %h want 08", resp_result); end
        checks++; if (resp_zero !== 1'b0) begin errors++; $display("FAIL single_zero got %b want 0", resp_zero); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        drain("single");
    endtask

    task automatic test_alu_ops();
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic [2:0] vc [2];
        logic [7:0] vr [2];
        logic       vz [2];
        va[0] = 8'h2A; vb[0] = 8'h2A; vc[0] = 3'b110; vr[0] = 8'h00; vz[0] = 1'b1;
        va[1] = 8'h02; vb[1] = 8'h07; vc[1] = 3'b111; vr[1] = 8'h01; vz[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid     = 2'b10;
            req_a[15:8]   = va[i];
            req_b[15:8]   = vb[i];
            req_ctrl[5:3] = vc[i];
            resp_ready    = 2'b10;
            #1;
            checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL alu%0d_req_ready got %b want 10", i, req_ready); end
            @(posedge clk); #1;
            req_valid = 2'b00;
            checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL alu%0d_resp_valid got %b want 10", i, resp_valid); end
            checks++; if (resp_result !== vr[i]) begin errors++; $display("FAIL alu%0d_result got %h want %h", i, resp_result, vr[i]); end
            checks++; if (resp_zero !== vz[i]) begin errors++; $display("FAIL alu%0d_zero got %b want %b", i, resp_zero, vz[i]); end
        end
        drain("alu");
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_w;
        logic [7:0] exp_r;
        @(negedge clk);
        req_valid  = 2'b11;
        req_a      = {8'h10, 8'h01};
        req_b      = {8'h20, 8'h01};
        req_ctrl   = {3'b001, 3'b010};
        resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_w = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (i % 2 == 0) ? 8'h02 : 8'h30;
            if (i != 0) @(negedge clk);
            #1;
            checks++; if (req_ready !== exp_w) begin errors++; $display("FAIL b2b%0d_req_ready got %b want %b", i, req_ready, exp_w); end
            @(posedge clk); #1;
            checks++; if (resp_valid !== exp_w) begin errors++; $display("FAIL b2b%0d_resp_valid got %b want %b", i, resp_valid, exp_w); end
            checks++; if (resp_result !== exp_r) begin errors++; $display("FAIL b2b%0d_result got %h want %h", i, resp_result, exp_r); end
        end
        drain("b2b");
    endtask

    task automatic test_stall();
        @(negedge clk);
        req_valid     = 2'b01;
        req_a         = {8'h05, 8'h0F};
        req_b         = {8'h03, 8'hF0};
        req_ctrl      = {3'b000, 3'b001};
        resp_ready    = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_first_req_ready got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b11;
        checks++; if (resp_result !== 8'hFF) begin errors++; $display("FAIL stall_first_result got %h want ff", resp_result); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            resp_ready = (i < 3) ? 2'b00 : 2'b10;
            #1;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall%0d_req_ready got %b want 00", i, req_ready); end
            checks++; if (alu_a !== 8'h00 || alu_control !== 3'b000)
                begin errors++; $display("FAIL stall%0d_alu_idle got %h %b want 00 000", i, alu_a, alu_control); end
            @(posedge clk); #1;
            checks++; if (resp_valid !== 2'b01 || resp_result !== 8'hFF)
                begin errors++; $display("FAIL stall%0d_hold got %b %h want 01 ff", i, resp_valid, resp_result); end
        end
        @(negedge clk);
        resp_ready = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release_req_ready got %b want 10", req_ready); end
        @(posedge clk); #1;
        checks++; if (resp_valid !== 2'b10 || resp_result !== 8'h01)
            begin errors++; $display("FAIL stall_release_resp got %b %h want 10 01", resp_valid, resp_result); end
        drain("stall");
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        req_valid     = 2'b01;
        req_a[7:0]    = 8'h05;
        req_b[7:0]    = 8'h03;
        req_ctrl[2:0] = 3'b010;
        resp_ready    = 2'b00;
        @(posedge clk); #1;
        req_valid = 2'b11;
        checks++; if (busy !== 1'b1 || resp_result !== 8'h08)
            begin errors++; $display("FAIL rsthold_pre got busy %b result %h want 1 08", busy, resp_result); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rsthold_resp_valid got %b want 00", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsthold_busy got %b want 0", busy); end
        checks++; if (resp_result !== 8'h00) begin errors++; $display("FAIL rsthold_result got %h want 00", resp_result); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rsthold_req_ready got %b want 00", req_ready); end
        @(negedge clk);
        reset      = 1'b1;
        resp_ready = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rsthold_first_grant got %b want 01", req_ready); end
        @(posedge clk); #1;
        checks++; if (resp_valid !== 2'b01 || resp_result !== 8'h08)
            begin errors++; $display("FAIL rsthold_resp got %b %h want 01 08", resp_valid, resp_result); end
        drain("rsthold");
    endtask

    task automatic test_only_req1();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [2:0] vc [3];
        logic [7:0] vr [3];
        logic       vz [3];
        va[0] = 8'h80; vb[0] = 8'h01; vc[0] = 3'b011; vr[0] = 8'h01; vz[0] = 1'b0;
        va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 3'b010; vr[1] = 8'h00; vz[1] = 1'b1;
        va[2] = 8'h0C; vb[2] = 8'h0A; vc[2] = 3'b100; vr[2] = 8'h04; vz[2] = 1'b0;
        resp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid     = 2'b10;
            req_a[15:8]   = va[i];
            req_b[15:8]   = vb[i];
            req_ctrl[5:3] = vc[i];
            #1;
            checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL only1_%0d_req_ready got %b want 10", i, req_ready); end
            @(posedge clk); #1;
            checks++; if (resp_valid !== 2'b10 || resp_result !== vr[i] || resp_zero !== vz[i])
                begin errors++; $display("FAIL only1_%0d_resp got %b %h %b want 10 %h %b", i, resp_valid, resp_result, resp_zero, vr[i], vz[i]); end
        end
        req_valid = 2'b00;
        #1;
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_control !== 3'b000 || req_ready !== 2'b00)
            begin errors++; $display("FAIL only1_idle_alu got %h %h %b %b want 00 00 000 00", alu_a, alu_b, alu_control, req_ready); end
        drain("only1");
    endtask

    initial begin
        test_reset();
        test_single();
        test_alu_ops();
        test_back_to_back();
        test_stall();
        test_reset_hold();
        test_only_req1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
